// File: rtl/clave_verificador.sv
// Purpose : keypad PIN checker; assembles DIGITS key codes, compares with CODE, pulses grant/deny, locks out after repeated failures.
// Latency : final digit accepted at edge N -> compare at N -> acceso/denegado/bloqueado visible after edge N+1.
// Backpress: none; keypresses arriving during compare/grant/deny/lockout are dropped, not queued.
// Ports   : clk, reset (async, active-high); tecla[2:0] key code (0 = cancel), tecla_valida decoder done level;
//           acceso/denegado one-cycle pulses, bloqueado lockout level, digitos buffered count, intentos failure count.
module clave_verificador #(
    parameter int                  DIGITS         = 4,
    parameter logic [3*DIGITS-1:0] CODE           = 12'o1234,
    parameter int                  MAX_INTENTOS   = 3,
    parameter int                  TIMEOUT_CYCLES = 50_000_000,
    parameter int                  LOCK_CYCLES    = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] tecla,
    input  logic       tecla_valida,
    output logic       acceso,
    output logic       denegado,
    output logic       bloqueado,
    output logic [2:0] digitos,
    output logic [1:0] intentos
);
    localparam int BW = 3 * DIGITS;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD     = LW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    DIGITS_L      = 3'(DIGITS);
    localparam logic [1:0]    INTENTOS_LAST = 2'(MAX_INTENTOS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRADA,
        S_CHECK,
        S_GRANT,
        S_DENY,
        S_LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [2:0]      digitos_q, digitos_d;
    logic [1:0]      intentos_q, intentos_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [LW-1:0]   lock_q, lock_d;
    logic            prev_q, prev_d;

    logic            pulso;
    logic            es_digito;

    // The decoder holds done high for several cycles; only the rising edge is a keypress.
    assign pulso     = tecla_valida & ~prev_q;
    assign es_digito = (tecla != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            digitos_q  <= '0;
            intentos_q <= '0;
            tmo_q      <= '0;
            lock_q     <= '0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            digitos_q  <= digitos_d;
            intentos_q <= intentos_d;
            tmo_q      <= tmo_d;
            lock_q     <= lock_d;
            prev_q     <= prev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        digitos_d  = digitos_q;
        intentos_d = intentos_q;
        tmo_d      = tmo_q;
        lock_d     = lock_q;
        prev_d     = tecla_valida;

        case (state_q)
            S_IDLE: begin
                if (pulso && es_digito) begin
                    buf_d     = BW'(tecla);
                    digitos_d = 3'd1;
                    tmo_d     = '0;
                    state_d   = (DIGITS == 1) ? S_CHECK : S_ENTRADA;
                end
            end

            S_ENTRADA: begin
                // A keypress on the expiry edge takes priority over the timeout.
                if (pulso) begin
                    if (es_digito) begin
                        buf_d     = (buf_q << 3) | BW'(tecla);
                        digitos_d = digitos_q + 3'd1;
                        tmo_d     = '0;
                        if (digitos_q + 3'd1 == DIGITS_L) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        buf_d     = '0;
                        digitos_d = '0;
                        tmo_d     = '0;
                        state_d   = S_IDLE;
                    end
                end else if (tmo_q == TIMEOUT_LAST) begin
                    buf_d     = '0;
                    digitos_d = '0;
                    tmo_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_CHECK: begin
                buf_d     = '0;
                digitos_d = '0;
                if (buf_q == CODE) begin
                    intentos_d = '0;
                    state_d    = S_GRANT;
                end else if (intentos_q == INTENTOS_LAST) begin
                    // Loaded with LOCK_CYCLES-1 and exits after reaching zero, so
                    // bloqueado is high for exactly LOCK_CYCLES cycles.
                    lock_d  = LOCK_LOAD;
                    state_d = S_LOCKED;
                end else begin
                    intentos_d = intentos_q + 2'd1;
                    state_d    = S_DENY;
                end
            end

            S_GRANT: state_d = S_IDLE;
            S_DENY:  state_d = S_IDLE;

            S_LOCKED: begin
                if (lock_q == '0) begin
                    intentos_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    lock_d = lock_q - LW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs come straight from the state register; no input paths.
    assign acceso    = (state_q == S_GRANT);
    assign denegado  = (state_q == S_DENY);
    assign bloqueado = (state_q == S_LOCKED);
    assign digitos   = digitos_q;
    assign intentos  = intentos_q;

endmodule

// File: tb/tb_clave_verificador.sv
module tb_clave_verificador;
    localparam int          DIGITS         = 4;
    localparam logic [11:0] CODE           = 12'o1234;
    localparam int          MAX_INTENTOS   = 3;
    localparam int          TIMEOUT_CYCLES = 10;
    localparam int          LOCK_CYCLES    = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] tecla = 3'd0;
    logic       tecla_valida = 1'b0;
    logic       acceso, denegado, bloqueado;
    logic [2:0] digitos;
    logic [1:0] intentos;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   acc_cnt = 0, den_cnt = 0, blk_cnt = 0;
    int   last_acc = -1, last_den = -1, first_blk = -1;
    logic blk_prev = 1'b0;

    // Reference model: digits entered so far and consecutive failures.
    int m_q[$];
    int m_fail = 0;

    clave_verificador #(
        .DIGITS(DIGITS), .CODE(CODE), .MAX_INTENTOS(MAX_INTENTOS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .tecla(tecla), .tecla_valida(tecla_valida),
        .acceso(acceso), .denegado(denegado), .bloqueado(bloqueado),
        .digitos(digitos), .intentos(intentos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (acceso) begin acc_cnt++; last_acc = cyc; end
        if (denegado) begin den_cnt++; last_den = cyc; end
        if (bloqueado) begin
            if (!blk_prev) first_blk = cyc;
            blk_cnt++;
        end
        blk_prev = bloqueado;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    // Returns expected digit count after this key; outcome 0 none, 1 grant, 2 deny, 3 lockout.
    function automatic int model_key(input int k, output int outcome);
        int n;
        int val;
        outcome = 0;
        if (k == 0) begin
            m_q.delete();
            return 0;
        end
        m_q.push_back(k);
        n = m_q.size();
        if (n == DIGITS) begin
            val = 0;
            foreach (m_q[i]) val = val * 8 + m_q[i];
            m_q.delete();
            if (val == int'(CODE)) begin
                outcome = 1;
                m_fail = 0;
            end else if (m_fail + 1 == MAX_INTENTOS) begin
                outcome = 3;
                m_fail = 0;
            end else begin
                m_fail++;
                outcome = 2;
            end
        end
        return n;
    endfunction

    task automatic press(input logic [2:0] k, input int hold, input int gap,
                         output int p, output logic [2:0] dig);
        @(negedge clk);
        tecla = k;
        tecla_valida = 1'b1;
        @(posedge clk);
        #1;
        p = cyc;
        dig = digitos;
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        tecla_valida = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic enter_code(input logic [11:0] code, input string tag);
        int a0, d0, b0, p, pp, n, outc;
        logic [2:0] k, dig;
        a0 = acc_cnt; d0 = den_cnt; b0 = blk_cnt;
        outc = 0;
        p = 0;
        for (int i = 0; i < DIGITS; i++) begin
            k = code[11 - 3*i -: 3];
            press(k, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), p, dig);
            n = model_key(int'(k), outc);
            checks++;
            if (dig !== 3'(n)) begin
                errors++;
                $display("FAIL %s digitos after digit %0d: got %0d expected %0d", tag, i, dig, n);
            end
        end
        if (outc == 3) begin
            for (int j = 0; j < 3; j++) begin
                press(3'($urandom_range(1, 7)), 1, 1, pp, dig);
                checks++;
                if (dig !== 3'd0) begin
                    errors++;
                    $display("FAIL %s digitos while locked: got %0d expected 0", tag, dig);
                end
            end
            while (cyc < p + LOCK_CYCLES + 2) @(negedge clk);
        end else begin
            while (cyc < p + 3) @(negedge clk);
        end
        checks++;
        if (acc_cnt - a0 !== ((outc == 1) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s acceso pulses: got %0d expected %0d", tag, acc_cnt - a0, (outc == 1) ? 1 : 0);
        end
        checks++;
        if (den_cnt - d0 !== ((outc == 2) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s denegado pulses: got %0d expected %0d", tag, den_cnt - d0, (outc == 2) ? 1 : 0);
        end
        checks++;
        if (blk_cnt - b0 !== ((outc == 3) ? LOCK_CYCLES : 0)) begin
            errors++;
            $display("FAIL %s bloqueado cycles: got %0d expected %0d", tag, blk_cnt - b0, (outc == 3) ? LOCK_CYCLES : 0);
        end
        if (outc == 1) begin
            checks++;
            if (last_acc !== p + 1) begin
                errors++;
                $display("FAIL %s acceso cycle: got %0d expected %0d", tag, last_acc, p + 1);
            end
        end else if (outc == 2) begin
            checks++;
            if (last_den !== p + 1) begin
                errors++;
                $display("FAIL %s denegado cycle: got %0d expected %0d", tag, last_den, p + 1);
            end
        end else if (outc == 3) begin
            checks++;
            if (first_blk !== p + 1) begin
                errors++;
                $display("FAIL %s bloqueado start: got %0d expected %0d", tag, first_blk, p + 1);
            end
        end
        checks++;
        if (digitos !== 3'd0) begin
            errors++;
            $display("FAIL %s digitos after code: got %0d expected 0", tag, digitos);
        end
        checks++;
        if (intentos !== 2'(m_fail)) begin
            errors++;
            $display("FAIL %s intentos: got %0d expected %0d", tag, intentos, m_fail);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({acceso, denegado, bloqueado, digitos, intentos} !== 8'd0) begin
            errors++;
            $display("FAIL reset outputs: got %b expected 0", {acceso, denegado, bloqueado, digitos, intentos});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_codes();
        enter_code(12'o1234, "correct");
        enter_code(12'o1235, "wrong");
        enter_code(12'o1234, "correct_after_wrong");
    endtask

    task automatic test_lockout();
        enter_code(12'o1235, "lock1");
        enter_code(12'o7777, "lock2");
        enter_code(12'o1111, "lock3");
        enter_code(12'o1234, "after_lock");
    endtask

    task automatic test_cancel();
        int a0, d0, p, n, o;
        logic [2:0] dig;
        logic [2:0] keys [3];
        keys[0] = 3'd1; keys[1] = 3'd2; keys[2] = 3'd0;
        a0 = acc_cnt; d0 = den_cnt;
        for (int i = 0; i < 3; i++) begin
            press(keys[i], 2, 1, p, dig);
            n = model_key(int'(keys[i]), o);
            checks++;
            if (dig !== 3'(n)) begin
                errors++;
                $display("FAIL cancel digitos step %0d: got %0d expected %0d", i, dig, n);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if ((acc_cnt - a0) + (den_cnt - d0) !== 0) begin
            errors++;
            $display("FAIL cancel pulses: got %0d expected 0", (acc_cnt - a0) + (den_cnt - d0));
        end
    endtask

    task automatic test_timeout();
        int p, p2, n, o;
        logic [2:0] dig;
        press(3'd1, 1, 0, p, dig);
        n = model_key(1, o);
        while (cyc < p + TIMEOUT_CYCLES - 1) @(negedge clk);
        checks++;
        if (digitos !== 3'd1) begin
            errors++;
            $display("FAIL timeout early: digitos got %0d expected 1", digitos);
        end
        @(negedge clk);
        m_q.delete();
        checks++;
        if (digitos !== 3'd0) begin
            errors++;
            $display("FAIL timeout expiry: digitos got %0d expected 0", digitos);
        end
        press(3'd1, 1, 0, p, dig);
        n = model_key(1, o);
        while (cyc < p + TIMEOUT_CYCLES - 2) @(negedge clk);
        press(3'd2, 1, 1, p2, dig);
        n = model_key(2, o);
        checks++;
        if (p2 !== p + TIMEOUT_CYCLES || dig !== 3'(n)) begin
            errors++;
            $display("FAIL timeout race: edge got %0d expected %0d, digitos got %0d expected %0d",
                     p2, p + TIMEOUT_CYCLES, dig, n);
        end
        press(3'd0, 1, 1, p, dig);
        n = model_key(0, o);
    endtask

    task automatic test_held_key();
        int mx, n, o;
        @(negedge clk);
        tecla = 3'd1;
        tecla_valida = 1'b1;
        n = model_key(1, o);
        @(posedge clk);
        #1;
        checks++;
        if (digitos !== 3'(n)) begin
            errors++;
            $display("FAIL held first: digitos got %0d expected %0d", digitos, n);
        end
        mx = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (int'(digitos) > mx) mx = int'(digitos);
        end
        checks++;
        if (mx !== 1) begin
            errors++;
            $display("FAIL held max digitos: got %0d expected 1", mx);
        end
        tecla_valida = 1'b0;
        m_q.delete();
        repeat (2) @(negedge clk);
        checks++;
        if (digitos !== 3'd0) begin
            errors++;
            $display("FAIL held release: digitos got %0d expected 0", digitos);
        end
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({acceso, denegado, bloqueado, digitos, intentos} !== 8'd0) begin
            errors++;
            $display("FAIL %s async outputs: got %b expected 0", tag,
                     {acceso, denegado, bloqueado, digitos, intentos});
        end
        @(negedge clk);
        reset = 1'b0;
        m_q.delete();
        m_fail = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_async();
        int p, n, o;
        logic [2:0] dig;
        enter_code(12'o7777, "pre_reset_entry");
        for (int i = 1; i <= 2; i++) begin
            press(3'(i), 1, 1, p, dig);
            n = model_key(i, o);
        end
        checks++;
        if (digitos !== 3'd2 || intentos !== 2'd1) begin
            errors++;
            $display("FAIL mid_entry setup: digitos %0d intentos %0d, expected 2 and 1", digitos, intentos);
        end
        async_reset_check("mid_entry");
        enter_code(12'o7777, "pre_lock_a");
        enter_code(12'o6666, "pre_lock_b");
        for (int i = 0; i < DIGITS; i++) begin
            press(3'd5, 1, 1, p, dig);
            n = model_key(5, o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bloqueado !== 1'b1) begin
            errors++;
            $display("FAIL mid_lock setup: bloqueado got %b expected 1", bloqueado);
        end
        async_reset_check("mid_lock");
        enter_code(12'o1234, "after_async_reset");
    endtask

    task automatic test_random();
        logic [11:0] code;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                code = CODE;
            end else begin
                code = 12'd0;
                for (int i = 0; i < DIGITS; i++)
                    code = code | (12'($urandom_range(1, 7)) << (9 - 3*i));
            end
            enter_code(code, "random");
        end
    endtask

    initial begin
        test_reset();
        test_codes();
        test_lockout();
        test_cancel();
        test_timeout();
        test_held_key();
        test_reset_async();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
